// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Opcode encoding, FSM state encoding and the single-cycle
//               ALU function shared by the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [OP_W-1:0]   opcode_t;

  localparam opcode_t OP_ADD   = 4'd0;
  localparam opcode_t OP_SUB   = 4'd1;
  localparam opcode_t OP_AND   = 4'd2;
  localparam opcode_t OP_OR    = 4'd3;
  localparam opcode_t OP_XOR   = 4'd4;
  localparam opcode_t OP_SLL   = 4'd5;
  localparam opcode_t OP_SRL   = 4'd6;
  localparam opcode_t OP_SRA   = 4'd7;
  localparam opcode_t OP_SLT   = 4'd8;
  localparam opcode_t OP_PASSB = 4'd9;
  localparam opcode_t OP_MUL   = 4'd10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  // Opcodes 0..9 finish in one cycle; MUL and 11..15 are handled separately.
  function automatic logic is_single_cycle(input opcode_t op);
    return (op <= OP_PASSB);
  endfunction

  function automatic word_t alu_calc(input opcode_t op, input word_t a, input word_t b);
    word_t res;
    res = '0;
    case (op)
      OP_ADD:   res = a + b;
      OP_SUB:   res = a - b;
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_SLL:   res = a << b[4:0];
      OP_SRL:   res = a >> b[4:0];
      OP_SRA:   res = word_t'($signed(a) >>> b[4:0]);
      OP_SLT:   res = {31'd0, ($signed(a) < $signed(b))};
      OP_PASSB: res = b;
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : exec_unit_if
// Description : Decode-to-execute issue handshake plus the register-file
//               write port driven by the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface exec_unit_if;
  import exec_pkg::*;

  logic     inValid;
  logic     inReady;
  opcode_t  op;
  word_t    opA;
  word_t    opB;
  reg_idx_t destAddr;
  logic     writeEnable;
  reg_idx_t writeAddr;
  word_t    writeData;
  logic     illegalOp;
  logic     busy;

  // Decode side: issues ops, observes results and back-pressure.
  modport master (
    output inValid, op, opA, opB, destAddr,
    input  inReady, writeEnable, writeAddr, writeData, illegalOp, busy
  );

  // Execute side.
  modport slave (
    input  inValid, op, opA, opB, destAddr,
    output inReady, writeEnable, writeAddr, writeData, illegalOp, busy
  );

endinterface
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : mul_iter
// Description : Iterative shift-add multiplier, one multiplier bit per cycle.
//               done is high during the last iteration and product then
//               carries the final low WIDTH bits. Used only when EXEC_MUL_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  output logic                  done,
  output logic [WIDTH-1:0]      product
);

  localparam int CNT_W = $clog2(MUL_CYCLES);

  logic             active;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc_next;

  // Partial-product accumulation for the current multiplier bit.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  assign done    = active && (count == CNT_W'(MUL_CYCLES - 1));
  assign product = acc_next;

  // Load on start, then shift/accumulate until the last iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (start) begin
      active <= 1'b1;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= '0;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : exec_unit
// Description : Execute stage. Single-cycle ALU ops write the register file
//               the cycle after acceptance; the iterative multiply (built only
//               when EXEC_MUL_EN is defined) stalls issue for MUL_CYCLES
//               cycles. Without EXEC_MUL_EN opcode 10 is reported illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input wire logic   clk,
  input wire logic   rst,
  exec_unit_if.slave bus
);

  // Only the 32-bit configuration with one iteration per bit is supported.
  if (WIDTH != 32 || MUL_CYCLES != WIDTH) begin : g_bad_cfg
    $error("exec_unit: only WIDTH=32, MUL_CYCLES=32 is supported");
  end

  logic             ready;
  logic             accept;
  logic             wr_en;
  reg_idx_t         wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             illegal_pulse;

  assign accept = bus.inValid && ready;

`ifdef EXEC_MUL_EN
  logic [0:0]       state;
  reg_idx_t         mul_dest;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign ready     = (state == ST_IDLE);
  assign bus.busy  = (state == ST_MUL);
  assign mul_start = accept && (bus.op == OP_MUL);

  mul_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.opA),
    .b       (bus.opB),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign ready    = 1'b1;
  assign bus.busy = 1'b0;
`endif

  // Issue/retire: one write strobe per completed op, illegal ops only pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      illegal_pulse <= 1'b0;
`ifdef EXEC_MUL_EN
      state         <= ST_IDLE;
      mul_dest      <= '0;
`endif
    end else begin
      wr_en         <= 1'b0;
      illegal_pulse <= 1'b0;
      if (accept) begin
        if (is_single_cycle(bus.op)) begin
          wr_en   <= 1'b1;
          wr_addr <= bus.destAddr;
          wr_data <= alu_calc(bus.op, bus.opA, bus.opB);
        end
`ifdef EXEC_MUL_EN
        else if (bus.op == OP_MUL) begin
          state    <= ST_MUL;
          mul_dest <= bus.destAddr;
        end
`endif
        else begin
          illegal_pulse <= 1'b1;
        end
      end
`ifdef EXEC_MUL_EN
      // Last multiply iteration: retire the product and reopen issue.
      if (state == ST_MUL && mul_done) begin
        wr_en   <= 1'b1;
        wr_addr <= mul_dest;
        wr_data <= mul_product;
        state   <= ST_IDLE;
      end
`endif
    end
  end

  assign bus.inReady     = ready;
  assign bus.writeEnable = wr_en;
  assign bus.writeAddr   = wr_addr;
  assign bus.writeData   = wr_data;
  assign bus.illegalOp   = illegal_pulse;

endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_unit
// Description : Self-checking bench for exec_unit: directed cases plus
//               randomized ops checked against an arithmetic reference model.
//               Follows the EXEC_MUL_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_unit;

`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_unit_if bus();

  exec_unit #(.WIDTH(32), .MUL_CYCLES(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Last value written to the regfile port (held while writeEnable is low).
  logic [2:0]  exp_addr = 3'd0;
  logic [31:0] exp_data = 32'd0;

  // Reference model written from the operation definitions.
  function automatic logic [31:0] ref_calc(input int op, input logic [31:0] a, input logic [31:0] b);
    int          sh;
    longint      sa, sb, d, q;
    logic [63:0] p;
    sh = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: begin p = {32'd0, a} * (64'd1 << sh); return p[31:0]; end
      6: begin p = {32'd0, a} / (64'd1 << sh); return p[31:0]; end
      7: begin
        d = longint'(1) << sh;
        q = sa / d;
        if (sa < 0 && q * d != sa) q = q - 1;
        return q[31:0];
      end
      8: return (sa < sb) ? 32'd1 : 32'd0;
      9: return b;
      10: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_legal(input int op);
    return (op <= 9) || (op == 10 && MUL_EN);
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int op, input logic [31:0] a, input logic [31:0] b, input logic [2:0] d);
    bus.inValid  = v;
    bus.op       = 4'(op);
    bus.opA      = a;
    bus.opB      = b;
    bus.destAddr = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 0, 32'd0, 32'd0, 3'd0);
    step();
    step();
    rst = 1'b0;
    exp_addr = 3'd0;
    exp_data = 32'd0;
    vectors++; if (bus.inReady !== 1'b1) begin miscompares++; $display("FAIL reset_inReady got=%b exp=1", bus.inReady); end
    vectors++; if (bus.writeEnable !== 1'b0) begin miscompares++; $display("FAIL reset_writeEnable got=%b exp=0", bus.writeEnable); end
    vectors++; if (bus.writeAddr !== 3'd0) begin miscompares++; $display("FAIL reset_writeAddr got=%0d exp=0", bus.writeAddr); end
    vectors++; if (bus.writeData !== 32'd0) begin miscompares++; $display("FAIL reset_writeData got=%h exp=0", bus.writeData); end
    vectors++; if (bus.illegalOp !== 1'b0) begin miscompares++; $display("FAIL reset_illegalOp got=%b exp=0", bus.illegalOp); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_add();
    drive(1'b1, 0, 32'hFFFF_FFFF, 32'd2, 3'd3);
    step();
    drive(1'b0, 0, 32'd0, 32'd0, 3'd0);
    vectors++; if (bus.writeEnable !== 1'b1) begin miscompares++; $display("FAIL add_we got=%b exp=1", bus.writeEnable); end
    vectors++; if (bus.writeAddr !== 3'd3) begin miscompares++; $display("FAIL add_addr got=%0d exp=3", bus.writeAddr); end
    vectors++; if (bus.writeData !== 32'h0000_0001) begin miscompares++; $display("FAIL add_data got=%h exp=00000001", bus.writeData); end
    step();
    vectors++; if (bus.writeEnable !== 1'b0) begin miscompares++; $display("FAIL add_we_drop got=%b exp=0", bus.writeEnable); end
    vectors++; if (bus.writeData !== 32'h0000_0001) begin miscompares++; $display("FAIL add_hold got=%h exp=00000001", bus.writeData); end
    exp_addr = 3'd3;
    exp_data = 32'h1;
  endtask

  task automatic test_back_to_back();
    int          ops [3] = '{1, 7, 8};
    logic [31:0] as  [3] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs  [3] = '{32'd7, 32'd4, 32'd1};
    logic [31:0] res [3] = '{32'hFFFF_FFFE, 32'hF800_0000, 32'h0000_0001};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], 3'(i + 1));
      step();
      vectors++; if (bus.writeEnable !== 1'b1) begin miscompares++; $display("FAIL b2b_we[%0d] got=%b exp=1", i, bus.writeEnable); end
      vectors++; if (bus.writeAddr !== 3'(i + 1)) begin miscompares++; $display("FAIL b2b_addr[%0d] got=%0d exp=%0d", i, bus.writeAddr, i + 1); end
      vectors++; if (bus.writeData !== res[i]) begin miscompares++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, bus.writeData, res[i]); end
    end
    exp_addr = 3'd3;
    exp_data = 32'h1;
    drive(1'b0, 0, 32'd0, 32'd0, 3'd0);
    step();
    vectors++; if (bus.writeEnable !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_we got=%b exp=0", bus.writeEnable); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 13, 32'h1234, 32'h5678, 3'd6);
    step();
    drive(1'b1, 0, 32'd10, 32'd20, 3'd2);
    vectors++; if (bus.illegalOp !== 1'b1) begin miscompares++; $display("FAIL illegal_pulse got=%b exp=1", bus.illegalOp); end
    vectors++; if (bus.writeEnable !== 1'b0) begin miscompares++; $display("FAIL illegal_we got=%b exp=0", bus.writeEnable); end
    vectors++; if (bus.writeData !== exp_data) begin miscompares++; $display("FAIL illegal_hold got=%h exp=%h", bus.writeData, exp_data); end
    step();
    drive(1'b0, 0, 32'd0, 32'd0, 3'd0);
    vectors++; if (bus.illegalOp !== 1'b0) begin miscompares++; $display("FAIL illegal_clear got=%b exp=0", bus.illegalOp); end
    vectors++; if (bus.writeEnable !== 1'b1) begin miscompares++; $display("FAIL illegal_next_we got=%b exp=1", bus.writeEnable); end
    vectors++; if (bus.writeData !== 32'd30) begin miscompares++; $display("FAIL illegal_next_data got=%h exp=0000001e", bus.writeData); end
    exp_addr = 3'd2;
    exp_data = 32'd30;
    step();
  endtask

  task automatic test_mul();
`ifdef EXEC_MUL_EN
    int low = 0;
    int n   = 0;
    bit got = 1'b0;
    drive(1'b1, 10, 32'h0001_0003, 32'h0000_0010, 3'd5);
    step();
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL mul_busy got=%b exp=1", bus.busy); end
    if (bus.inReady === 1'b0) low++;
    // ADD offered during the stall; it must wait for the write cycle.
    drive(1'b1, 0, 32'd100, 32'd23, 3'd6);
    while (!got && n < 40) begin
      step();
      n++;
      if (bus.writeEnable === 1'b1) got = 1'b1;
      else if (bus.inReady === 1'b0) low++;
    end
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL mul_timeout got=%b exp=1", got); end
    vectors++; if (low !== 32) begin miscompares++; $display("FAIL mul_stall_cycles got=%0d exp=32", low); end
    vectors++; if (bus.writeAddr !== 3'd5) begin miscompares++; $display("FAIL mul_addr got=%0d exp=5", bus.writeAddr); end
    vectors++; if (bus.writeData !== 32'h0010_0030) begin miscompares++; $display("FAIL mul_data got=%h exp=00100030", bus.writeData); end
    vectors++; if (bus.inReady !== 1'b1) begin miscompares++; $display("FAIL mul_ready_in_write got=%b exp=1", bus.inReady); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mul_busy_clear got=%b exp=0", bus.busy); end
    step();
    drive(1'b0, 0, 32'd0, 32'd0, 3'd0);
    vectors++; if (bus.writeEnable !== 1'b1) begin miscompares++; $display("FAIL mul_add_we got=%b exp=1", bus.writeEnable); end
    vectors++; if (bus.writeAddr !== 3'd6) begin miscompares++; $display("FAIL mul_add_addr got=%0d exp=6", bus.writeAddr); end
    vectors++; if (bus.writeData !== 32'd123) begin miscompares++; $display("FAIL mul_add_data got=%h exp=0000007b", bus.writeData); end
    exp_addr = 3'd6;
    exp_data = 32'd123;
    step();
`else
    drive(1'b1, 10, 32'h0001_0003, 32'h0000_0010, 3'd5);
    step();
    drive(1'b0, 0, 32'd0, 32'd0, 3'd0);
    vectors++; if (bus.illegalOp !== 1'b1) begin miscompares++; $display("FAIL nomul_illegal got=%b exp=1", bus.illegalOp); end
    vectors++; if (bus.writeEnable !== 1'b0) begin miscompares++; $display("FAIL nomul_we got=%b exp=0", bus.writeEnable); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bus.inReady !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL nomul_ready[%0d] got=%b/%b exp=1/0", i, bus.inReady, bus.busy); end
      step();
    end
`endif
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_reset_mid_mul();
    int writes = 0;
    drive(1'b1, 10, $urandom | 32'h1, $urandom | 32'h1, 3'd4);
    step();
    drive(1'b0, 0, 32'd0, 32'd0, 3'd0);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_addr = 3'd0;
    exp_data = 32'd0;
    vectors++; if (bus.inReady !== 1'b1) begin miscompares++; $display("FAIL rstmul_ready got=%b exp=1", bus.inReady); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmul_busy got=%b exp=0", bus.busy); end
    for (int i = 0; i < 40; i++) begin
      if (bus.writeEnable === 1'b1) writes++;
      step();
    end
    vectors++; if (writes !== 0) begin miscompares++; $display("FAIL rstmul_writes got=%0d exp=0", writes); end
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 300; it++) begin
      bit          v;
      int          op;
      logic [31:0] a, b, exp;
      logic [2:0]  d;
      v  = ($urandom_range(0, 3) != 0);
      op = int'($urandom_range(0, 15));
      a  = pick_operand();
      b  = pick_operand();
      d  = 3'($urandom_range(0, 7));
      exp = ref_calc(op, a, b);
      drive(v, op, a, b, d);
      step();
      drive(1'b0, 0, 32'd0, 32'd0, 3'd0);
      if (v && op == 10 && MUL_EN) begin
        int n   = 0;
        bit got = (bus.writeEnable === 1'b1);
        while (!got && n < 40) begin
          step();
          n++;
          if (bus.writeEnable === 1'b1) got = 1'b1;
        end
        vectors++; if (got !== 1'b1 || n !== 32) begin miscompares++; $display("FAIL rnd_mul_latency[%0d] got=%0d exp=32", it, n); end
        vectors++; if (bus.writeData !== exp || bus.writeAddr !== d) begin miscompares++; $display("FAIL rnd_mul[%0d] %h*%h got=%h@%0d exp=%h@%0d", it, a, b, bus.writeData, bus.writeAddr, exp, d); end
        exp_addr = d;
        exp_data = exp;
      end else if (v && ref_legal(op)) begin
        vectors++; if (bus.writeEnable !== 1'b1 || bus.illegalOp !== 1'b0) begin miscompares++; $display("FAIL rnd_we[%0d] op=%0d got=%b/%b exp=1/0", it, op, bus.writeEnable, bus.illegalOp); end
        vectors++; if (bus.writeData !== exp || bus.writeAddr !== d) begin miscompares++; $display("FAIL rnd_data[%0d] op=%0d a=%h b=%h got=%h@%0d exp=%h@%0d", it, op, a, b, bus.writeData, bus.writeAddr, exp, d); end
        exp_addr = d;
        exp_data = exp;
      end else if (v) begin
        vectors++; if (bus.writeEnable !== 1'b0 || bus.illegalOp !== 1'b1) begin miscompares++; $display("FAIL rnd_illegal[%0d] op=%0d got=%b/%b exp=0/1", it, op, bus.writeEnable, bus.illegalOp); end
        vectors++; if (bus.writeData !== exp_data || bus.writeAddr !== exp_addr) begin miscompares++; $display("FAIL rnd_illegal_hold[%0d] got=%h@%0d exp=%h@%0d", it, bus.writeData, bus.writeAddr, exp_data, exp_addr); end
      end else begin
        vectors++; if (bus.writeEnable !== 1'b0 || bus.illegalOp !== 1'b0) begin miscompares++; $display("FAIL rnd_idle[%0d] got=%b/%b exp=0/0", it, bus.writeEnable, bus.illegalOp); end
        vectors++; if (bus.writeData !== exp_data || bus.writeAddr !== exp_addr) begin miscompares++; $display("FAIL rnd_idle_hold[%0d] got=%h@%0d exp=%h@%0d", it, bus.writeData, bus.writeAddr, exp_data, exp_addr); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 0, 32'd0, 32'd0, 3'd0);
    test_reset();
    test_add();
    test_back_to_back();
    test_illegal();
    test_mul();
`ifdef EXEC_MUL_EN
    test_reset_mid_mul();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exec_unit.md
# exec_unit

Execute stage of the decode/execute datapath. Accepts a decoded operation plus two 32-bit operands read from the 8×32 register file, computes the result, and drives the register file's write port (writeEnable/writeAddr/writeData) directly. Most ops complete in one cycle and can issue back-to-back; the optional multiply is an iterative 32-cycle operation that back-pressures the decode stage through a valid/ready handshake.

## Interface
- WIDTH, 32, operand/result width (only 32 is supported)
- MUL_CYCLES, 32, multiply iterations (equals WIDTH)
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous, active-high reset
- inValid  input  1  decode presents an op this cycle
- inReady  output  1  exec_unit can accept; transfer when inValid && inReady
- op  input  4  opcode (see Operation)
- opA  input  32  operand A (regfile rdA)
- opB  input  32  operand B (regfile rdB)
- destAddr  input  3  destination register index
- writeEnable  output  1  regfile write strobe, one cycle per result
- writeAddr  output  3  regfile write index
- writeData  output  32  regfile write data
- illegalOp  output  1  one-cycle pulse: accepted op was illegal
- busy  output  1  high while a multiply is in progress

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 PASSB, 10 MUL, 11–15 illegal.
- ADD/SUB wrap mod 2^32. Shifts use opB[4:0] only. SLT is signed: result 32'd1 if $signed(opA) < $signed(opB), else 0. PASSB: result = opB. MUL: low 32 bits of opA*opB (signedness-independent).
- FSM states: IDLE, MUL.
  - IDLE: inReady=1. On accept of a single-cycle op, register result, writeAddr=destAddr, writeEnable=1 for the next cycle; stay IDLE. On accept of MUL, latch opA/opB/destAddr, clear accumulator and counter, go to MUL. On accept of an illegal op, writeEnable=0, illegalOp=1 next cycle.
  - MUL: inReady=0, busy=1. Each cycle: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++. On the edge where count reaches MUL_CYCLES-1, register the final acc into writeData with writeEnable=1 and return to IDLE.
- writeEnable is high for exactly one cycle per completed op, never for illegal ops. writeAddr/writeData hold their last values while writeEnable=0.
- Reset values: inReady=1 after reset, writeEnable=0, writeAddr=0, writeData=0, illegalOp=0, busy=0, state=IDLE.
- Reset mid-multiply aborts it: no write is produced, and the FSM returns to IDLE.
- inValid while inReady=0 is ignored. Decode must hold the op stable until it is accepted.

## Timing
- Single-cycle op accepted at edge E0: writeEnable is high in the cycle after E0. Back-to-back accepts give one write per cycle.
- MUL accepted at E0: busy/inReady change after E0. The write is visible after edge E32. Because inReady=1 in that same cycle, a new op can be accepted while the MUL result is being written.
- The regfile has no bypass. Decode must not issue a consumer op in the same cycle that its producer's writeEnable is high.

## Configuration
- EXEC_MUL_EN defined: the MUL path and the MUL state are built.
- EXEC_MUL_EN undefined: opcode 10 is treated as illegal (illegalOp pulse, no write). busy is tied to 0 and inReady to 1.

## Structure
- Shared package exec_pkg holds the opcode localparams (OP_ADD … OP_MUL) and the FSM state encoding.
- One sub-module, mul_iter: the shift-add datapath (start, operands, done, product). It is instantiated only under EXEC_MUL_EN.

## Test plan
- Reset, then ADD opA=0xFFFFFFFF, opB=2, dest=3 → next cycle writeEnable=1, writeAddr=3, writeData=0x00000001.
- Back-to-back SUB 5-7 → 0xFFFFFFFE, then SRA 0x80000000>>4 → 0xF8000000, then SLT -1<1 → 1 → three consecutive write cycles with the correct data.
- MUL 0x0001_0003 × 0x0000_0010, dest=5 → inReady low for 32 cycles, then one write of 0x0010_0030 to r5; an ADD offered during that window is accepted only in the write cycle.
- Illegal op 13 → illegalOp pulse, writeEnable stays 0, next op proceeds normally.
- Assert rst at cycle 10 of a MUL → no write ever occurs; inReady=1 and busy=0 after the reset edge.
- Build without EXEC_MUL_EN, issue op 10 → illegalOp=1, no write, inReady never drops.
